// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel seconds timer.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    // Number of bits needed to count 0..clk_hz-1 (at least one bit).
    function automatic int presc_width(input int clk_hz);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < clk_hz) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: prescaler, seconds counter, run state and reload latch.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CLK_HZ = 10000,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             abort,
    input  logic             periodic,
    input  logic [CNT_W-1:0] seconds,
    output logic             busy,
    output logic             finished,
    output logic [CNT_W-1:0] remaining
);

    localparam int            PW        = presc_width(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    ch_state_t        state_reg, state_next;
    logic [PW-1:0]    presc_reg, presc_next;
    logic [CNT_W-1:0] rem_reg, rem_next;
    logic [CNT_W-1:0] reload_reg, reload_next;
    logic             periodic_reg, periodic_next;
    logic             finished_reg, finished_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            presc_reg    <= '0;
            rem_reg      <= '0;
            reload_reg   <= '0;
            periodic_reg <= 1'b0;
            finished_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            rem_reg      <= rem_next;
            reload_reg   <= reload_next;
            periodic_reg <= periodic_next;
            finished_reg <= finished_next;
        end
    end

    // Priority: abort, then start, then counting (only while enabled).
    always_comb begin
        state_next    = state_reg;
        presc_next    = presc_reg;
        rem_next      = rem_reg;
        reload_next   = reload_reg;
        periodic_next = periodic_reg;
        finished_next = 1'b0;
        if (abort) begin
            state_next = IDLE;
            presc_next = '0;
            rem_next   = '0;
        end else if (start) begin
            reload_next   = seconds;
            periodic_next = periodic;
            presc_next    = '0;
            if (seconds == '0) begin
                // A zero-length timer expires immediately, even while frozen.
                state_next    = IDLE;
                rem_next      = '0;
                finished_next = 1'b1;
            end else begin
                state_next = RUN;
                rem_next   = seconds;
            end
        end else if (state_reg == RUN && enable) begin
            if (presc_reg == PRESC_MAX) begin
                presc_next = '0;
                if (rem_reg <= CNT_W'(1)) begin
                    finished_next = 1'b1;
                    if (periodic_reg) begin
                        rem_next = reload_reg;
                    end else begin
                        rem_next   = '0;
                        state_next = IDLE;
                    end
                end else begin
                    rem_next = rem_reg - CNT_W'(1);
                end
            end else begin
                presc_next = presc_reg + PW'(1);
            end
        end
    end

    always_comb begin
        busy      = (state_reg == RUN);
        finished  = finished_reg;
        remaining = rem_reg;
    end

endmodule

// File: rtl/multi_timer.sv
// CH independent countdown channels sharing clock, reset and the global enable.
module multi_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ = 10000,
    parameter int CH     = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [CH-1:0]       start,
    input  logic [CH-1:0]       abort,
    input  logic [CH-1:0]       periodic,
    input  logic [CH*CNT_W-1:0] seconds,
    output logic [CH-1:0]       busy,
    output logic [CH-1:0]       finished,
    output logic [CH*CNT_W-1:0] remaining
);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            timer_channel #(
                .CLK_HZ(CLK_HZ),
                .CNT_W (CNT_W)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .enable   (enable),
                .start    (start[gi]),
                .abort    (abort[gi]),
                .periodic (periodic[gi]),
                .seconds  (seconds[gi*CNT_W +: CNT_W]),
                .busy     (busy[gi]),
                .finished (finished[gi]),
                .remaining(remaining[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: expected finished pulses are queued at stimulus time.
module tb_multi_timer;

    localparam int HZ = 10;
    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic [CH-1:0]   start = '0;
    logic [CH-1:0]   abort = '0;
    logic [CH-1:0]   periodic = '0;
    logic [CH*W-1:0] seconds = '0;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   finished;
    logic [CH*W-1:0] remaining;

    typedef struct {
        int         ch;
        int         cyc;
        logic       busy;
        logic [7:0] rem;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t0;

    multi_timer #(.CLK_HZ(HZ), .CH(CH), .CNT_W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .start    (start),
        .abort    (abort),
        .periodic (periodic),
        .seconds  (seconds),
        .busy     (busy),
        .finished (finished),
        .remaining(remaining)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    // Monitor: every finished pulse must match the oldest queued expectation of its channel.
    always @(negedge clk) begin : monitor
        int   found;
        exp_t e;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                if (finished[c]) begin
                    found = -1;
                    for (int k = 0; k < exp_q.size(); k++) begin
                        if (found < 0 && exp_q[k].ch == c) found = k;
                    end
                    if (found < 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_fin ch%0d @cyc %0d: got finished=1, required 0", c, cyc);
                    end else begin
                        e = exp_q[found];
                        exp_q.delete(found);
                        $display("fin ch%0d cyc=%0d busy=%0d rem=%0d", c, cyc, busy[c], remaining[c*W +: W]);
                        check("fin_cycle", cyc, e.cyc);
                        check("fin_busy", {31'd0, busy[c]}, {31'd0, e.busy});
                        check("fin_rem", {24'd0, remaining[c*W +: W]}, {24'd0, e.rem});
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic push(input int ch, input int at, input logic b, input logic [7:0] r);
        exp_t e;
        e.ch = ch; e.cyc = at; e.busy = b; e.rem = r;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; the start is sampled on the following posedge.
    task automatic pulse_start(input int ch, input int s, input logic per);
        start[ch] = 1'b1;
        periodic[ch] = per;
        seconds[ch*W +: W] = s[7:0];
        @(negedge clk);
        start[ch] = 1'b0;
        periodic[ch] = 1'b0;
    endtask

    task automatic pulse_abort(input int ch);
        abort[ch] = 1'b1;
        @(negedge clk);
        abort[ch] = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {28'd0, busy}, 0);
        check("rst_fin", {28'd0, finished}, 0);
        check("rst_rem", remaining, 0);
        reset = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // Reset mid-count: channel must drop to IDLE at once and never finish
        t0 = cyc;
        pulse_start(0, 3, 1'b0);
        wait_cyc(t0 + 12);
        check("pre_rst_rem0", {24'd0, remaining[7:0]}, 2);
        reset = 1'b0;
        #1;
        check("async_rst_busy0", {31'd0, busy[0]}, 0);
        check("async_rst_rem0", {24'd0, remaining[7:0]}, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_cyc(cyc + 40);

        // One-shot ch0, S=3
        t0 = cyc;
        push(0, t0 + 31, 1'b0, 8'd0);
        pulse_start(0, 3, 1'b0);
        check("os_busy", {31'd0, busy[0]}, 1);
        wait_cyc(t0 + 10); check("os_rem_a", {24'd0, remaining[7:0]}, 3);
        wait_cyc(t0 + 11); check("os_rem_b", {24'd0, remaining[7:0]}, 2);
        wait_cyc(t0 + 21); check("os_rem_c", {24'd0, remaining[7:0]}, 1);
        wait_cyc(t0 + 30); check("os_busy_late", {31'd0, busy[0]}, 1);
        wait_cyc(t0 + 40);
        check("os_queue", exp_q.size(), 0);

        // Periodic ch1, S=2
        t0 = cyc;
        push(1, t0 + 21, 1'b1, 8'd2);
        push(1, t0 + 41, 1'b1, 8'd2);
        push(1, t0 + 61, 1'b1, 8'd2);
        pulse_start(1, 2, 1'b1);
        wait_cyc(t0 + 65);
        check("per_busy", {31'd0, busy[1]}, 1);
        pulse_abort(1);
        check("per_abort_busy", {31'd0, busy[1]}, 0);
        wait_cyc(t0 + 90);
        check("per_queue", exp_q.size(), 0);

        // Freeze ch2 for 7 cycles in a 3 s count
        t0 = cyc;
        push(2, t0 + 38, 1'b0, 8'd0);
        pulse_start(2, 3, 1'b0);
        wait_cyc(t0 + 12);
        enable = 1'b0;
        repeat (7) @(negedge clk);
        check("frz_rem", {24'd0, remaining[23:16]}, 2);
        enable = 1'b1;
        wait_cyc(t0 + 45);
        check("frz_queue", exp_q.size(), 0);

        // Abort ch0 on its expiry cycle
        t0 = cyc;
        pulse_start(0, 1, 1'b0);
        wait_cyc(t0 + 10);
        pulse_abort(0);
        check("abx_busy", {31'd0, busy[0]}, 0);
        check("abx_rem", {24'd0, remaining[7:0]}, 0);
        wait_cyc(t0 + 25);

        // Restart ch3: S=5 then S=1 at +15
        t0 = cyc;
        pulse_start(3, 5, 1'b0);
        wait_cyc(t0 + 15);
        push(3, t0 + 26, 1'b0, 8'd0);
        pulse_start(3, 1, 1'b0);
        wait_cyc(t0 + 60);
        check("rst3_queue", exp_q.size(), 0);

        // Start and abort together on ch2: abort wins
        start[2] = 1'b1;
        abort[2] = 1'b1;
        seconds[23:16] = 8'd2;
        @(negedge clk);
        start[2] = 1'b0;
        abort[2] = 1'b0;
        check("sa_busy", {31'd0, busy[2]}, 0);
        check("sa_rem", {24'd0, remaining[23:16]}, 0);
        wait_cyc(cyc + 25);

        // Zero-length start on ch1
        t0 = cyc;
        push(1, t0 + 1, 1'b0, 8'd0);
        pulse_start(1, 0, 1'b1);
        @(negedge clk);
        check("zero_busy", {31'd0, busy[1]}, 0);
        check("zero_fin_off", {31'd0, finished[1]}, 0);
        check("zero_queue", exp_q.size(), 0);

        // All four channels together, S=1..4
        t0 = cyc;
        for (int c = 0; c < CH; c++) begin
            push(c, t0 + 1 + (c + 1) * HZ, 1'b0, 8'd0);
            start[c] = 1'b1;
            seconds[c*W +: W] = 8'(c + 1);
        end
        @(negedge clk);
        start = '0;
        check("conc_busy", {28'd0, busy}, 15);
        wait_cyc(t0 + 50);
        check("conc_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised successor of the single-channel seconds timer in the traffic-light controller. It provides CH independent countdown channels, each with its own prescaler, one-shot or periodic mode, abort, and a remaining-seconds readback. The traffic FSM uses it to time phases for several signal groups concurrently: main lights, turn arrows and pedestrian heads. It sits between the FSM and the 10 kHz system clock.

## Interface
Parameters:
- CLK_HZ, 10000: clk cycles per second; must be ≥2.
- CH, 4: number of channels, 1..16.
- CNT_W, 16: width of the seconds counter per channel.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0), applied to all state.
- enable  in  1  global run; low freezes every prescaler and counter.
- start  in  CH  per-channel load/start strobe, sampled on clk.
- abort  in  CH  per-channel stop, no finished pulse.
- periodic  in  CH  mode, sampled with start: 1 = auto-reload, 0 = one-shot.
- seconds  in  CH*CNT_W  per-channel duration; channel i uses bits [i*CNT_W +: CNT_W].
- busy  out  CH  channel is counting.
- finished  out  CH  one-cycle pulse at expiry.
- remaining  out  CH*CNT_W  whole seconds left, same packing as seconds.

## Operation
- Reset (reset=0): all channels go to IDLE. busy=0, finished=0, remaining=0, prescalers=0.
- Each channel has two states, IDLE and RUN, plus a latched reload value and periodic flag.

Start:
- start[i]=1 with seconds S>0 loads remaining=S and reload=S, latches periodic[i], clears the prescaler and enters RUN. This applies in either state; start during RUN restarts the channel.
- S=0 gives finished=1 on the next cycle and the channel stays or returns to IDLE, regardless of mode.

Counting:
- In RUN with enable=1, the prescaler counts 0..CLK_HZ-1.
- When the prescaler wraps, remaining decrements.
- When a decrement takes remaining from 1 to 0, finished[i] pulses for one cycle in the same registered update.
- On expiry in one-shot mode the channel goes to IDLE with remaining=0.
- On expiry in periodic mode remaining reloads to reload instead of 0, the prescaler restarts from 0, and the channel stays in RUN.

Priority and freezing:
- Priority per channel: abort > start > count. Abort returns to IDLE with remaining=0 and no finished pulse, even in the expiry cycle.
- enable=0 freezes the prescaler and remaining. start and abort are still accepted and loading occurs, but counting does not resume until enable=1. finished never asserts while enable=0, except for the S=0 case.
- busy[i] = (state==RUN).
- Channels are fully independent; simultaneous events on different channels do not interact.

## Timing
- Start latency: start sampled at edge t gives busy=1 and remaining=S visible after edge t.
- finished is high during the cycle following edge t+S·CLK_HZ. That is exactly S·CLK_HZ enabled cycles after the start edge, counting only edges with enable=1.
- One-shot: busy falls on the same edge finished rises.
- Periodic: finished pulses every S·CLK_HZ enabled cycles, with no gap cycle, and busy stays high.
- Prescaler width is ceil(log2(CLK_HZ)). Counter arithmetic is unsigned CNT_W bits, and remaining never underflows.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- timer_pkg holds:
  - the channel state enum (IDLE, RUN);
  - a function computing the prescaler width from CLK_HZ.
- Sub-module timer_channel is one channel: prescaler, counter, state and reload latch.
- multi_timer instantiates CH copies in a generate loop, fans out clk/reset/enable and slices the packed buses.

## Test plan
Directed tests use CLK_HZ=10, CH=4, CNT_W=8.
- Reset while busy: hold reset=0 → busy=0, finished=0, remaining=0. Release, then start ch0 with S=3 and pulse reset=0 mid-count → ch0 goes IDLE immediately, remaining=0, and no finished pulse appears afterwards.
- One-shot: start ch0, S=3, enable=1 → remaining steps 3,2,1 every 10 cycles. finished[0] is high exactly one cycle, 30 cycles after start, and busy[0] falls on that edge.
- Periodic: start ch1, S=2, periodic=1 → finished[1] pulses at +20, +40 and +60 cycles. busy[1] stays 1 and remaining reloads to 2 on each pulse.
- Freeze: enable=0 for 7 cycles in the middle of a 3 s count on ch2 → finished[2] arrives at start+37.
- Abort and restart:
  - abort ch0 on its expiry cycle → no finished pulse, channel goes IDLE;
  - start ch3 with S=5, then restart it with S=1 at +15 → finished[3] at +25 only;
  - start and abort in the same cycle → abort wins.
- Zero and concurrency:
  - S=0 start → one-cycle finished next cycle, busy stays 0;
  - all four channels started together with S=1,2,3,4 → finished pulses at +10, +20, +30 and +40 respectively.
